// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and sizes for the RC4 key-scheduling shuffle
package rc4_pkg;
  localparam int S_SIZE = 256;
  localparam int KEY_BYTES_DEF = 3;
  typedef logic [7:0] byte_t;
  localparam byte_t I_LAST = byte_t'(S_SIZE - 1);
  typedef enum logic [3:0] {
    IDLE, RD_SI, WAIT_SI, GET_SI, CALC_J, RD_SJ, WAIT_SJ, GET_SJ, WR_SI, WR_SJ, INC_I, DONE
  } ksa_state_t;
endpackage

// File: rtl/ksa_shuffle_fsm_if.sv
// ksa_shuffle_fsm_if: controller handshake, key and S RAM port of the shuffle stage
interface ksa_shuffle_fsm_if #(parameter int KEY_BYTES = rc4_pkg::KEY_BYTES_DEF);
  import rc4_pkg::*;
  logic start_L2;
  logic [8*KEY_BYTES-1:0] secret_key;
  byte_t q_loop2;
  byte_t address_loop2;
  byte_t data_loop2;
  logic wren_loop2;
  logic finish_L2;
  modport master (output start_L2, secret_key, q_loop2, input address_loop2, data_loop2, wren_loop2, finish_L2);
  modport slave (input start_L2, secret_key, q_loop2, output address_loop2, data_loop2, wren_loop2, finish_L2);
endinterface

// File: rtl/ksa_shuffle_fsm_key_byte_sel.sv
// key_byte_sel: picks key byte idx from the key, byte 0 being the most significant
module key_byte_sel import rc4_pkg::*; #(
  parameter int KEY_BYTES = KEY_BYTES_DEF,
  parameter int KW = 2
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [KW-1:0]          idx,
  output byte_t                  key_byte
);
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++)
      key_byte = (idx == KW'(n)) ? key[8*(KEY_BYTES-1-n) +: 8] : key_byte;
  end
endmodule

// File: rtl/ksa_shuffle_fsm.sv
// ksa_shuffle_fsm: RC4 KSA swap loop driving a single-port S RAM with registered outputs
module ksa_shuffle_fsm import rc4_pkg::*; #(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input logic clk,
  input logic reset,
  ksa_shuffle_fsm_if.slave bus
);
  localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  ksa_state_t state_q, state_d;
  byte_t i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, addr_q, addr_d, data_q, data_d, kb;
  logic [KW-1:0] k_q, k_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic wren_q, wren_d;
  key_byte_sel #(.KEY_BYTES(KEY_BYTES), .KW(KW)) u_sel (.key(key_q), .idx(k_q), .key_byte(kb));
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    si_d = si_q;
    sj_d = sj_q;
    key_d = key_q;
    unique case (state_q)
      IDLE: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        if (bus.start_L2) begin
          key_d = bus.secret_key;
          state_d = RD_SI;
        end
      end
      RD_SI: state_d = WAIT_SI;
      WAIT_SI: state_d = GET_SI;
      GET_SI: begin
        si_d = bus.q_loop2;
        state_d = CALC_J;
      end
      CALC_J: begin
        j_d = j_q + si_q + kb;
        state_d = RD_SJ;
      end
      RD_SJ: state_d = WAIT_SJ;
      WAIT_SJ: state_d = GET_SJ;
      GET_SJ: begin
        sj_d = bus.q_loop2;
        state_d = WR_SI;
      end
      WR_SI: state_d = WR_SJ;
      WR_SJ: state_d = INC_I;
      INC_I: begin
        state_d = (i_q == I_LAST) ? DONE : RD_SI;
        i_d = (i_q == I_LAST) ? i_q : i_q + 8'd1;
        k_d = (i_q == I_LAST) ? k_q : (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // RAM outputs are set up from the next state so they are valid for the whole state cycle
    addr_d = (state_d inside {RD_SJ, WR_SJ}) ? j_d : (state_d inside {RD_SI, WR_SI}) ? i_d : addr_q;
    wren_d = state_d inside {WR_SI, WR_SJ};
    data_d = (state_d == WR_SI) ? sj_d : (state_d == WR_SJ) ? si_d : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      si_q <= '0;
      sj_q <= '0;
      key_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      si_q <= si_d;
      sj_q <= sj_d;
      key_q <= key_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wren_q <= wren_d;
    end
  end
  assign bus.address_loop2 = addr_q;
  assign bus.data_loop2 = data_q;
  assign bus.wren_loop2 = wren_q;
  assign bus.finish_L2 = (state_q == DONE);
endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// tb_ksa_shuffle_fsm: random and directed KSA runs against a software RC4 key schedule
module tb_ksa_shuffle_fsm;
  import rc4_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_load = 1'b0;
  always #5 clk = ~clk;
  ksa_shuffle_fsm_if bus();
  ksa_shuffle_fsm dut (.clk(clk), .reset(reset), .bus(bus.slave));
  byte_t mem [S_SIZE];
  byte_t ref_s [S_SIZE];
  byte_t addr_r;
  always @(posedge clk) begin
    if (ram_load) for (int k = 0; k < S_SIZE; k++) mem[k] <= byte_t'(k);
    else if (bus.wren_loop2) mem[bus.address_loop2] <= bus.data_loop2;
    addr_r <= bus.address_loop2;
  end
  assign bus.q_loop2 = mem[addr_r];
  logic [15:0] wlog [$];
  int fin_q [$];
  int wren_cnt, rst_cyc, act;
  int errors = 0;
  int checks = 0;
  logic [23:0] key;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic ref_ksa(input logic [23:0] k);
    byte_t j = 8'd0;
    byte_t t, kb;
    for (int i = 0; i < S_SIZE; i++) begin
      kb = byte_t'(k >> (8 * (KEY_BYTES_DEF - 1 - i % KEY_BYTES_DEF)));
      j = j + ref_s[i] + kb;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask
  task automatic load_ram;
    @(negedge clk) ram_load = 1'b1;
    @(negedge clk) ram_load = 1'b0;
    for (int k = 0; k < S_SIZE; k++) ref_s[k] = byte_t'(k);
  endtask
  function automatic int s_diff();
    int n = 0;
    for (int k = 0; k < S_SIZE; k++) if (mem[k] !== ref_s[k]) n++;
    return n;
  endfunction
  function automatic logic [15:0] wl(input int k);
    return (wlog.size() > k) ? wlog[k] : 16'hxxxx;
  endfunction
  function automatic int fq(input int k);
    return (fin_q.size() > k) ? fin_q[k] : -1;
  endfunction
  task automatic run_ksa(input logic [23:0] k, input int hold, input int pulse_at, input int n_fin,
                         input int rst_at, input int limit);
    wlog.delete();
    fin_q.delete();
    wren_cnt = 0;
    rst_cyc = 0;
    @(negedge clk);
    bus.secret_key = k;
    bus.start_L2 = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (c >= hold) bus.start_L2 = (c == pulse_at);
      if (c == pulse_at) bus.secret_key = 24'($urandom);
      if (bus.wren_loop2) begin
        wren_cnt++;
        wlog.push_back({bus.address_loop2, bus.data_loop2});
      end
      if (bus.finish_L2) fin_q.push_back(c);
      if (rst_at > 0 && c >= rst_at && bus.wren_loop2) begin
        reset = 1'b1;
        rst_cyc = c;
        break;
      end
      if (fin_q.size() >= n_fin && c >= fin_q[fin_q.size()-1] + 2) break;
    end
    bus.start_L2 = 1'b0;
  endtask
  initial begin
    bus.start_L2 = 1'b0;
    bus.secret_key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(bus.address_loop2), 0);
    chk("rst_data", 32'(bus.data_loop2), 0);
    chk("rst_wren", 32'(bus.wren_loop2), 0);
    chk("rst_finish", 32'(bus.finish_L2), 0);
    reset = 1'b0;
    load_ram();
    run_ksa(24'h000000, 1, 0, 1, 0, 3000);
    ref_ksa(24'h000000);
    chk("k0_w0", 32'(wl(0)), 32'h0000);
    chk("k0_w1", 32'(wl(1)), 32'h0000);
    chk("k0_w2", 32'(wl(2)), 32'h0101);
    chk("k0_w3", 32'(wl(3)), 32'h0101);
    chk("k0_w4", 32'(wl(4)), 32'h0203);
    chk("k0_w5", 32'(wl(5)), 32'h0302);
    chk("k0_fin_count", 32'(fin_q.size()), 1);
    chk("k0_fin_cycle", 32'(fq(0)), 2561);
    chk("k0_fin_after", 32'(bus.finish_L2), 0);
    chk("k0_wren_count", 32'(wren_cnt), 512);
    chk("k0_s_diff", 32'(s_diff()), 0);
    load_ram();
    run_ksa(24'h000249, 1, 0, 1, 0, 3000);
    ref_ksa(24'h000249);
    chk("k249_fin_cycle", 32'(fq(0)), 2561);
    chk("k249_fin_count", 32'(fin_q.size()), 1);
    chk("k249_wren_count", 32'(wren_cnt), 512);
    chk("k249_s_diff", 32'(s_diff()), 0);
    repeat (2) begin
      key = 24'($urandom);
      load_ram();
      run_ksa(key, 1, 0, 1, 0, 3000);
      ref_ksa(key);
      chk("rand_fin_cycle", 32'(fq(0)), 2561);
      chk("rand_s_diff", 32'(s_diff()), 0);
    end
    load_ram();
    run_ksa(24'h000249, 1, 500, 1, 0, 3000);
    ref_ksa(24'h000249);
    chk("pulse_fin_count", 32'(fin_q.size()), 1);
    chk("pulse_fin_cycle", 32'(fq(0)), 2561);
    chk("pulse_s_diff", 32'(s_diff()), 0);
    load_ram();
    run_ksa(24'($urandom), 1, 0, 1, 1000, 3000);
    chk("mid_rst_cycle", 32'(rst_cyc), 1008);
    chk("mid_rst_no_fin", 32'(fin_q.size()), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_wren", 32'(bus.wren_loop2), 0);
    chk("mid_rst_finish", 32'(bus.finish_L2), 0);
    chk("mid_rst_addr", 32'(bus.address_loop2), 0);
    reset = 1'b0;
    act = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.wren_loop2 || bus.finish_L2 || bus.address_loop2 != 8'd0) act++;
    end
    chk("mid_rst_idle", 32'(act), 0);
    key = 24'($urandom);
    load_ram();
    run_ksa(key, 1, 0, 1, 0, 3000);
    ref_ksa(key);
    chk("restart_fin_cycle", 32'(fq(0)), 2561);
    chk("restart_s_diff", 32'(s_diff()), 0);
    key = 24'($urandom);
    load_ram();
    run_ksa(key, 3000, 0, 2, 0, 6000);
    ref_ksa(key);
    ref_ksa(key);
    chk("held_fin_count", 32'(fin_q.size()), 2);
    chk("held_fin0", 32'(fq(0)), 2561);
    chk("held_fin1", 32'(fq(1)), 5123);
    chk("held_wren_count", 32'(wren_cnt), 1024);
    chk("held_s_diff", 32'(s_diff()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
